// File: rtl/spi_sif0.sv
// SPI target for the 32-bit register frame (RnW, address, data; MSB first).
// Pins are oversampled in CLK and each decoded frame becomes one local-bus master access.
module spi_sif0 #(
   parameter int unsigned P_ADDR_WIDTH = 15,
   parameter int unsigned P_DATA_WIDTH = 16,
   parameter int unsigned P_TO_WIDTH   = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    SPI_CSN,
   input  logic                    SPI_SCL,
   input  logic                    SPI_SDI,
   output logic                    SPI_SDO,
   output logic                    SPI_SDO_t,
   output logic                    LB_REQ,
   output logic                    LB_RNW,
   output logic [P_ADDR_WIDTH-1:0] LB_ADR,
   output logic [P_DATA_WIDTH-1:0] LB_WDAT,
   input  logic [P_DATA_WIDTH-1:0] LB_RDAT,
   input  logic                    LB_ACK,
   output logic                    SPI_ERR
);

   localparam int unsigned CW =
      $clog2(((P_ADDR_WIDTH > P_DATA_WIDTH) ? P_ADDR_WIDTH : P_DATA_WIDTH) + 1);
   localparam logic [P_TO_WIDTH-1:0] TO_LAST = {{(P_TO_WIDTH-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_IDLE, S_RNW, S_ADDR, S_DATA, S_WREQ, S_WAIT
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              csn_sync_q, csn_sync_d;
   logic [2:0]              scl_sync_q, scl_sync_d;
   logic [1:0]              sdi_sync_q, sdi_sync_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    rnw_q, rnw_d;
   logic [P_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [P_DATA_WIDTH-1:0] rx_q, rx_d;
   logic [P_DATA_WIDTH-1:0] tx_q, tx_d;
   logic                    sdo_q, sdo_d;
   logic                    sdo_t_q, sdo_t_d;
   logic                    rd_wait_q, rd_wait_d;
   logic                    lb_req_q, lb_req_d;
   logic                    lb_rnw_q, lb_rnw_d;
   logic [P_ADDR_WIDTH-1:0] lb_adr_q, lb_adr_d;
   logic [P_DATA_WIDTH-1:0] lb_wdat_q, lb_wdat_d;
   logic [P_TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
   logic                    err_q, err_d;
   logic                    issue_rd, issue_wr;
   logic                    csn_fall, csn_rise, scl_rise, scl_fall, sdi;

   assign csn_fall = csn_sync_q[2] & ~csn_sync_q[1];
   assign csn_rise = ~csn_sync_q[2] & csn_sync_q[1];
   assign scl_rise = ~scl_sync_q[2] & scl_sync_q[1];
   assign scl_fall = scl_sync_q[2] & ~scl_sync_q[1];
   assign sdi      = sdi_sync_q[1];

   always_comb begin
      csn_sync_d = {csn_sync_q[1:0], SPI_CSN};
      scl_sync_d = {scl_sync_q[1:0], SPI_SCL};
      sdi_sync_d = {sdi_sync_q[0], SPI_SDI};
      state_d    = state_q;
      cnt_d      = cnt_q;
      rnw_d      = rnw_q;
      adr_d      = adr_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      sdo_d      = tx_q[P_DATA_WIDTH-1];
      sdo_t_d    = sdo_t_q;
      rd_wait_d  = rd_wait_q;
      lb_req_d   = lb_req_q;
      lb_rnw_d   = lb_rnw_q;
      lb_adr_d   = lb_adr_q;
      lb_wdat_d  = lb_wdat_q;
      to_cnt_d   = to_cnt_q;
      err_d      = 1'b0;
      issue_rd   = 1'b0;
      issue_wr   = 1'b0;

      // CSN released before the last data bit abandons the frame from any shifting state
      if (csn_rise && (state_q inside {S_RNW, S_ADDR, S_DATA})) begin
         state_d   = S_IDLE;
         sdo_t_d   = 1'b1;
         err_d     = 1'b1;
         rd_wait_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (csn_fall) begin
               if (lb_req_q) begin
                  state_d = S_WAIT;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_RNW;
               end
            end
            S_RNW: if (scl_rise) begin
               rnw_d   = sdi;
               cnt_d   = CW'(P_ADDR_WIDTH - 1);
               state_d = S_ADDR;
            end
            S_ADDR: if (scl_rise) begin
               adr_d = {adr_q[P_ADDR_WIDTH-2:0], sdi};
               if (cnt_q == '0) begin
                  state_d = S_DATA;
                  cnt_d   = CW'(P_DATA_WIDTH);
                  if (rnw_q) begin
                     issue_rd  = 1'b1;
                     tx_d      = '0;
                     sdo_t_d   = 1'b0;
                     rd_wait_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_DATA: begin
               if (scl_rise) begin
                  rx_d  = {rx_q[P_DATA_WIDTH-2:0], sdi};
                  cnt_d = cnt_q - CW'(1);
                  // read data still outstanding at the first data rise: frame returns zeros
                  if (rd_wait_q) begin
                     err_d     = 1'b1;
                     rd_wait_d = 1'b0;
                  end
                  if (cnt_q == CW'(1)) begin
                     if (rnw_q) begin
                        state_d = S_WAIT;
                        sdo_t_d = 1'b1;
                     end else begin
                        state_d = S_WREQ;
                     end
                  end
               end else if (scl_fall && rnw_q && (cnt_q < CW'(P_DATA_WIDTH))) begin
                  tx_d = {tx_q[P_DATA_WIDTH-2:0], 1'b0};
               end
            end
            S_WREQ: begin
               issue_wr = 1'b1;
               state_d  = S_WAIT;
            end
            S_WAIT: begin
               sdo_t_d = 1'b1;
               if (csn_sync_q[1]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (lb_req_q) begin
         if (LB_ACK) begin
            lb_req_d = 1'b0;
            if (rd_wait_q && rd_wait_d) begin
               tx_d      = LB_RDAT;
               rd_wait_d = 1'b0;
            end
         end else if (to_cnt_q == TO_LAST) begin
            lb_req_d  = 1'b0;
            err_d     = 1'b1;
            rd_wait_d = 1'b0;
         end else begin
            to_cnt_d = to_cnt_q + P_TO_WIDTH'(1);
         end
      end

      if (issue_rd || issue_wr) begin
         lb_req_d = 1'b1;
         lb_rnw_d = issue_rd;
         lb_adr_d = adr_d;
         to_cnt_d = '0;
         if (issue_wr) lb_wdat_d = rx_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         csn_sync_q <= '1;
         scl_sync_q <= '0;
         sdi_sync_q <= '0;
         cnt_q      <= '0;
         rnw_q      <= 1'b0;
         adr_q      <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         sdo_q      <= 1'b0;
         sdo_t_q    <= 1'b1;
         rd_wait_q  <= 1'b0;
         lb_req_q   <= 1'b0;
         lb_rnw_q   <= 1'b0;
         lb_adr_q   <= '0;
         lb_wdat_q  <= '0;
         to_cnt_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         csn_sync_q <= csn_sync_d;
         scl_sync_q <= scl_sync_d;
         sdi_sync_q <= sdi_sync_d;
         cnt_q      <= cnt_d;
         rnw_q      <= rnw_d;
         adr_q      <= adr_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         sdo_q      <= sdo_d;
         sdo_t_q    <= sdo_t_d;
         rd_wait_q  <= rd_wait_d;
         lb_req_q   <= lb_req_d;
         lb_rnw_q   <= lb_rnw_d;
         lb_adr_q   <= lb_adr_d;
         lb_wdat_q  <= lb_wdat_d;
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
      end
   end

   assign SPI_SDO   = sdo_q;
   assign SPI_SDO_t = sdo_t_q;
   assign LB_REQ    = lb_req_q;
   assign LB_RNW    = lb_rnw_q;
   assign LB_ADR    = lb_adr_q;
   assign LB_WDAT   = lb_wdat_q;
   assign SPI_ERR   = err_q;

endmodule
